// File: rtl/execute_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : execute_pkg
// Brief  : Shared types for the execute stage: ALU ops, ARM condition codes,
//          forwarding selects and NZCV bit positions.
// Rev    : 1.0
// ============================================================================
package execute_pkg;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_ORR = 2'b11
    } alu_op_t;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0,
        COND_NE = 4'h1,
        COND_CS = 4'h2,
        COND_CC = 4'h3,
        COND_MI = 4'h4,
        COND_PL = 4'h5,
        COND_VS = 4'h6,
        COND_VC = 4'h7,
        COND_HI = 4'h8,
        COND_LS = 4'h9,
        COND_GE = 4'hA,
        COND_LT = 4'hB,
        COND_GT = 4'hC,
        COND_LE = 4'hD,
        COND_AL = 4'hE,
        COND_NV = 4'hF
    } cond_t;

    // 2'b11 is a second encoding for the register-file operand.
    typedef enum logic [1:0] {
        FWD_RD     = 2'b00,
        FWD_WB     = 2'b01,
        FWD_MEM    = 2'b10,
        FWD_RD_ALT = 2'b11
    } fwd_sel_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage
`default_nettype wire

// File: rtl/cond_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : cond_unit
// Brief  : Combinational ARM condition evaluation from a 4-bit NZCV value.
// Rev    : 1.0
// ============================================================================
module cond_unit
    import execute_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ex
);

    logic w_n;
    logic w_z;
    logic w_c;
    logic w_v;

    assign w_n = flags[FLAG_N];
    assign w_z = flags[FLAG_Z];
    assign w_c = flags[FLAG_C];
    assign w_v = flags[FLAG_V];

    always_comb begin
        cond_ex = 1'b1;
        case (cond_t'(cond))
            COND_EQ: cond_ex = w_z;
            COND_NE: cond_ex = ~w_z;
            COND_CS: cond_ex = w_c;
            COND_CC: cond_ex = ~w_c;
            COND_MI: cond_ex = w_n;
            COND_PL: cond_ex = ~w_n;
            COND_VS: cond_ex = w_v;
            COND_VC: cond_ex = ~w_v;
            COND_HI: cond_ex = w_c & ~w_z;
            COND_LS: cond_ex = ~w_c | w_z;
            COND_GE: cond_ex = (w_n == w_v);
            COND_LT: cond_ex = (w_n != w_v);
            COND_GT: cond_ex = ~w_z & (w_n == w_v);
            COND_LE: cond_ex = w_z | (w_n != w_v);
            default: cond_ex = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/execute_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : execute_stage
// Brief  : Pipeline execute stage: operand forwarding, ALU, condition check,
//          NZCV flag register and EX/MEM register. Forwarding muxes are built
//          only when EXECUTE_FWD_EN is defined.
// Rev    : 1.0
// ============================================================================
module execute_stage
    import execute_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] RD1E,
    input  logic [WIDTH-1:0] RD2E,
    input  logic [WIDTH-1:0] ExtImmE,
    input  logic             PCSrcE,
    input  logic             RegWriteE,
    input  logic             MemtoRegE,
    input  logic             MemWriteE,
    input  logic             BranchE,
    input  logic             ALUSrcE,
    input  logic [1:0]       ALUControlE,
    input  logic [1:0]       FlagWriteE,
    input  logic [3:0]       CondE,
    input  logic [3:0]       WA3E,
    input  logic [1:0]       ForwardAE,
    input  logic [1:0]       ForwardBE,
    input  logic [WIDTH-1:0] ResultW,
    output logic [3:0]       FlagsOut,
    output logic             BranchTakenE,
    output logic [WIDTH-1:0] ALUResultE,
    output logic [WIDTH-1:0] ALUOutM,
    output logic [WIDTH-1:0] WriteDataM,
    output logic [3:0]       WA3M,
    output logic             PCSrcM,
    output logic             RegWriteM,
    output logic             MemtoRegM,
    output logic             MemWriteM
);

    logic [3:0]       r_flags;
    logic [WIDTH-1:0] w_fwd_a;
    logic [WIDTH-1:0] w_fwd_b;
    logic [WIDTH-1:0] w_src_b;
    logic [WIDTH-1:0] w_src_b_eff;
    logic [WIDTH:0]   w_sum;
    logic             w_is_sub;
    logic             w_is_arith;
    logic             w_cond_ex;
    logic             w_n;
    logic             w_z;
    logic             w_c;
    logic             w_v;
    alu_op_t          w_op;

`ifdef EXECUTE_FWD_EN
    always_comb begin
        w_fwd_a = RD1E;
        case (fwd_sel_t'(ForwardAE))
            FWD_MEM: w_fwd_a = ALUOutM;
            FWD_WB:  w_fwd_a = ResultW;
            default: w_fwd_a = RD1E;
        endcase
    end

    always_comb begin
        w_fwd_b = RD2E;
        case (fwd_sel_t'(ForwardBE))
            FWD_MEM: w_fwd_b = ALUOutM;
            FWD_WB:  w_fwd_b = ResultW;
            default: w_fwd_b = RD2E;
        endcase
    end
`else
    // Without forwarding the hazard unit stalls on RAW; select inputs are inert.
    logic w_unused_fwd;
    assign w_unused_fwd = ^{ForwardAE, ForwardBE, ResultW};
    assign w_fwd_a      = RD1E;
    assign w_fwd_b      = RD2E;
`endif

    assign w_op        = alu_op_t'(ALUControlE);
    assign w_is_sub    = (w_op == ALU_SUB);
    assign w_is_arith  = (w_op == ALU_ADD) || (w_op == ALU_SUB);
    assign w_src_b     = ALUSrcE ? ExtImmE : w_fwd_b;
    assign w_src_b_eff = w_is_sub ? ~w_src_b : w_src_b;
    assign w_sum       = {1'b0, w_fwd_a} + {1'b0, w_src_b_eff}
                       + {{WIDTH{1'b0}}, w_is_sub};

    always_comb begin
        ALUResultE = w_sum[WIDTH-1:0];
        case (w_op)
            ALU_AND: ALUResultE = w_fwd_a & w_src_b;
            ALU_ORR: ALUResultE = w_fwd_a | w_src_b;
            default: ALUResultE = w_sum[WIDTH-1:0];
        endcase
    end

    assign w_n = ALUResultE[WIDTH-1];
    assign w_z = (ALUResultE == '0);
    assign w_c = w_is_arith & w_sum[WIDTH];
    assign w_v = w_is_arith
               & (w_fwd_a[WIDTH-1] == w_src_b_eff[WIDTH-1])
               & (w_sum[WIDTH-1] != w_fwd_a[WIDTH-1]);

    // Evaluated against the live register so a flag-setting op followed
    // directly by a conditional op needs no stall.
    cond_unit u_cond_unit (
        .cond    (CondE),
        .flags   (r_flags),
        .cond_ex (w_cond_ex)
    );

    assign BranchTakenE = BranchE & w_cond_ex;
    assign FlagsOut     = r_flags;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_flags    <= '0;
            ALUOutM    <= '0;
            WriteDataM <= '0;
            WA3M       <= '0;
            PCSrcM     <= 1'b0;
            RegWriteM  <= 1'b0;
            MemtoRegM  <= 1'b0;
            MemWriteM  <= 1'b0;
        end else begin
            if (FlagWriteE[1] && w_cond_ex) begin
                r_flags[FLAG_N] <= w_n;
                r_flags[FLAG_Z] <= w_z;
            end
            if (FlagWriteE[0] && w_cond_ex) begin
                r_flags[FLAG_C] <= w_c;
                r_flags[FLAG_V] <= w_v;
            end
            ALUOutM    <= ALUResultE;
            WriteDataM <= w_fwd_b;
            WA3M       <= WA3E;
            MemtoRegM  <= MemtoRegE;
            PCSrcM     <= PCSrcE & w_cond_ex;
            RegWriteM  <= RegWriteE & w_cond_ex;
            MemWriteM  <= MemWriteE & w_cond_ex;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_execute_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : tb_execute_stage
// Brief  : Scoreboard bench for execute_stage: directed cases then random
//          instructions checked against an arithmetic reference model.
// Rev    : 1.0
// ============================================================================
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] RD1E, RD2E, ExtImmE, ResultW;
    logic        PCSrcE, RegWriteE, MemtoRegE, MemWriteE, BranchE, ALUSrcE;
    logic [1:0]  ALUControlE, FlagWriteE, ForwardAE, ForwardBE;
    logic [3:0]  CondE, WA3E;
    logic [3:0]  FlagsOut;
    logic        BranchTakenE;
    logic [31:0] ALUResultE, ALUOutM, WriteDataM;
    logic [3:0]  WA3M;
    logic        PCSrcM, RegWriteM, MemtoRegM, MemWriteM;

    execute_stage #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .RD1E(RD1E), .RD2E(RD2E), .ExtImmE(ExtImmE),
        .PCSrcE(PCSrcE), .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE),
        .MemWriteE(MemWriteE), .BranchE(BranchE), .ALUSrcE(ALUSrcE),
        .ALUControlE(ALUControlE), .FlagWriteE(FlagWriteE), .CondE(CondE),
        .WA3E(WA3E), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .ResultW(ResultW), .FlagsOut(FlagsOut), .BranchTakenE(BranchTakenE),
        .ALUResultE(ALUResultE), .ALUOutM(ALUOutM), .WriteDataM(WriteDataM),
        .WA3M(WA3M), .PCSrcM(PCSrcM), .RegWriteM(RegWriteM),
        .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic [31:0] rd1, rd2, imm, resw;
        logic        pcsrc, regw, memtoreg, memw, branch, alusrc;
        logic [1:0]  aluc, fw, fa, fb;
        logic [3:0]  cond, wa3;
    } stim_t;

    typedef struct {
        logic [31:0] alu;
        logic        br;
        logic [31:0] aluoutm, wdm;
        logic [3:0]  wa3m, flags;
        logic        pcsrc, regw, memtoreg, memw;
    } exp_t;

    exp_t        sb_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [3:0]  m_flags   = 4'b0000;
    logic [31:0] m_aluoutm = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic stim_t nop();
        stim_t s;
        s.rst_n = 1'b1; s.rd1 = '0; s.rd2 = '0; s.imm = '0; s.resw = '0;
        s.pcsrc = 0; s.regw = 0; s.memtoreg = 0; s.memw = 0; s.branch = 0; s.alusrc = 0;
        s.aluc = 2'b00; s.fw = 2'b00; s.fa = 2'b00; s.fb = 2'b00;
        s.cond = 4'hE; s.wa3 = 4'h0;
        return s;
    endfunction

    function automatic bit cond_ok(input logic [3:0] cc, input logic [3:0] f);
        bit n, z, c, v;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        case (cc)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return c;
            4'h3: return !c;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return c && !z;
            4'h9: return !c || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] rd,
                                         input logic [31:0] resw);
`ifdef EXECUTE_FWD_EN
        if (sel == 2'b10) return m_aluoutm;
        if (sel == 2'b01) return resw;
`endif
        return rd;
    endfunction

    // Reference ALU in plain integer arithmetic: carry = unsigned overflow
    // (SUB: a >= b), overflow = signed result out of 32-bit range.
    task automatic alu_ref(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] r, output logic c, output logic v);
        longint sa, sb, sr;
        longint unsigned ua, ub;
        sa = longint'($signed(a)); sb = longint'($signed(b));
        ua = longint'({32'd0, a});  ub = longint'({32'd0, b});
        c = 0; v = 0; sr = 0;
        case (op)
            2'b00: begin r = a + b; c = (ua + ub) > 64'hFFFF_FFFF; sr = sa + sb; end
            2'b01: begin r = a - b; c = (a >= b); sr = sa - sb; end
            2'b10: r = a & b;
            default: r = a | b;
        endcase
        if (op[1] == 1'b0) v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    endtask

    task automatic issue(input stim_t s);
        exp_t        e;
        logic [31:0] fa, fb, srcb, r;
        logic        c, v, ok;
        @(negedge clk);
        reset = s.rst_n; RD1E = s.rd1; RD2E = s.rd2; ExtImmE = s.imm; ResultW = s.resw;
        PCSrcE = s.pcsrc; RegWriteE = s.regw; MemtoRegE = s.memtoreg; MemWriteE = s.memw;
        BranchE = s.branch; ALUSrcE = s.alusrc; ALUControlE = s.aluc; FlagWriteE = s.fw;
        ForwardAE = s.fa; ForwardBE = s.fb; CondE = s.cond; WA3E = s.wa3;

        fa   = pick(s.fa, s.rd1, s.resw);
        fb   = pick(s.fb, s.rd2, s.resw);
        srcb = s.alusrc ? s.imm : fb;
        alu_ref(s.aluc, fa, srcb, r, c, v);
        ok   = cond_ok(s.cond, m_flags);
        e.alu = r;
        e.br  = s.branch && ok;
        if (!s.rst_n) begin
            e.flags = 4'b0; e.aluoutm = '0; e.wdm = '0; e.wa3m = '0;
            e.pcsrc = 0; e.regw = 0; e.memtoreg = 0; e.memw = 0;
        end else begin
            e.flags = m_flags;
            if (s.fw[1] && ok) begin e.flags[3] = r[31]; e.flags[2] = (r == 0); end
            if (s.fw[0] && ok) begin e.flags[1] = c; e.flags[0] = v; end
            e.aluoutm = r; e.wdm = fb; e.wa3m = s.wa3; e.memtoreg = s.memtoreg;
            e.pcsrc = s.pcsrc && ok; e.regw = s.regw && ok; e.memw = s.memw && ok;
        end
        m_flags   = e.flags;
        m_aluoutm = e.aluoutm;
        sb_q.push_back(e);
    endtask

    // Monitor: combinational outputs just before the edge, EX/MEM outputs after it.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk); #4;
            if (sb_q.size() > 0) begin
                chk("ALUResultE", ALUResultE, sb_q[0].alu);
                chk("BranchTakenE", {31'd0, BranchTakenE}, {31'd0, sb_q[0].br});
            end
            @(posedge clk); #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("FlagsOut", {28'd0, FlagsOut}, {28'd0, e.flags});
                chk("ALUOutM", ALUOutM, e.aluoutm);
                chk("WriteDataM", WriteDataM, e.wdm);
                chk("WA3M", {28'd0, WA3M}, {28'd0, e.wa3m});
                chk("MCtrl", {28'd0, PCSrcM, RegWriteM, MemtoRegM, MemWriteM},
                             {28'd0, e.pcsrc, e.regw, e.memtoreg, e.memw});
            end
        end
    end

    initial begin
        stim_t s;
        s = nop(); s.rst_n = 0;
        issue(s); issue(s);

        // ADD 0x7FFFFFFF + 1 sets N and V
        s = nop(); s.rd1 = 32'h7FFF_FFFF; s.imm = 32'd1; s.alusrc = 1; s.fw = 2'b11;
        s.regw = 1; s.wa3 = 4'd3;
        issue(s);
        // SUB 5-5 then BEQ with no gap
        s = nop(); s.rd1 = 32'd5; s.rd2 = 32'd5; s.aluc = 2'b01; s.fw = 2'b11;
        issue(s);
        s = nop(); s.branch = 1; s.cond = 4'h0; s.rd1 = 32'h100; s.imm = 32'h20; s.alusrc = 1;
        issue(s);
        // NE with Z=1 squashes controls and flag writes
        s = nop(); s.cond = 4'h1; s.regw = 1; s.memw = 1; s.pcsrc = 1; s.fw = 2'b11;
        s.rd1 = 32'd1; s.rd2 = 32'd7; s.aluc = 2'b01; s.wa3 = 4'd9;
        issue(s);
        // Forward ALUOutM=0x10 into ADD imm 4
        s = nop(); s.rd1 = 32'h10; s.alusrc = 1; s.regw = 1;
        issue(s);
        s = nop(); s.fa = 2'b10; s.rd1 = 32'h99; s.imm = 32'd4; s.alusrc = 1; s.regw = 1;
        issue(s);
        // Store data forwarded from ResultW
        s = nop(); s.fb = 2'b01; s.resw = 32'hAB; s.rd2 = 32'h55; s.memw = 1; s.alusrc = 1;
        s.imm = 32'h40; s.rd1 = 32'h1000;
        issue(s);
        // Reset during a flag-setting SUB
        s = nop(); s.rst_n = 0; s.rd1 = 32'd1; s.rd2 = 32'd2; s.aluc = 2'b01; s.fw = 2'b11;
        s.regw = 1; s.memw = 1; s.pcsrc = 1;
        issue(s);
        s = nop(); s.rd1 = 32'd3; s.rd2 = 32'd3; s.aluc = 2'b01; s.fw = 2'b11;
        issue(s);

        for (int i = 0; i < 400; i++) begin
            s.rst_n    = ($urandom_range(0, 31) != 0);
            s.rd1      = $urandom;
            s.rd2      = ($urandom_range(0, 7) == 0) ? s.rd1 : 32'($urandom);
            s.imm      = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 255)) : 32'($urandom);
            s.resw     = $urandom;
            s.pcsrc    = 1'($urandom); s.regw = 1'($urandom); s.memtoreg = 1'($urandom);
            s.memw     = 1'($urandom); s.branch = 1'($urandom); s.alusrc = 1'($urandom);
            s.aluc     = 2'($urandom); s.fw = 2'($urandom);
            s.fa       = 2'($urandom); s.fb = 2'($urandom);
            s.cond     = 4'($urandom); s.wa3 = 4'($urandom);
            issue(s);
        end

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
        #3;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
